// File: rtl/spi_reg_slave_if.sv
// spi_reg_slave_if: SPI pins plus committed tuning/control outputs of the WSPR register front end
interface spi_reg_slave_if;
  logic nSpiCs;
  logic spiMosi;
  logic spiMiso;
  logic [31:0] tuningWord;
  logic tuneToggle;
  logic txEnable;
  logic [2:0] bandSel;
  logic [7:0] errCount;
  modport slave (
    input nSpiCs, spiMosi,
    output spiMiso, tuningWord, tuneToggle, txEnable, bandSel, errCount
  );
  modport master (
    output nSpiCs, spiMosi,
    input spiMiso, tuningWord, tuneToggle, txEnable, bandSel, errCount
  );
endinterface

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: decodes 40-bit SPI command frames into NCO tuning word, TX control and readback
module spi_reg_slave (
  input logic spiClk,
  input logic nReset,
  spi_reg_slave_if.slave bus
);
  logic [5:0] bitCount;
  logic [38:0] rxShift;
  logic [31:0] readShift, tunePend, tuneReg, readData, frameData;
  logic [7:0] cmd, frameCmd, errCnt;
  logic [3:0] ctrl;
  logic inFrame, tuneTog, csActive;
  assign csActive = ~bus.nSpiCs;
  assign cmd = {rxShift[6:0], bus.spiMosi};
  assign frameCmd = rxShift[38:31];
  assign frameData = {rxShift[30:0], bus.spiMosi};
  assign bus.spiMiso = readShift[31];
  assign bus.tuningWord = tuneReg;
  assign bus.tuneToggle = tuneTog;
  assign bus.txEnable = ctrl[0];
  assign bus.bandSel = ctrl[3:1];
  assign bus.errCount = errCnt;
  always_comb
    readData = cmd[6:0] == 7'd0 ? tuneReg :
               cmd[6:0] == 7'd1 ? tunePend :
               cmd[6:0] == 7'd3 ? {28'h0, ctrl} :
               cmd[6:0] == 7'd4 ? {16'h0, errCnt, 8'hA5} : 32'h0;
  // Chip select deassertion only rewinds the bit counter; all other state survives it
  always_ff @(posedge spiClk or posedge bus.nSpiCs)
    if (bus.nSpiCs) bitCount <= '0;
    else if (!nReset) bitCount <= '0;
    else if (bitCount != 6'd40) bitCount <= bitCount + 6'd1;
  always_ff @(posedge spiClk)
    if (!nReset) begin
      rxShift <= '0;
      readShift <= '0;
      tunePend <= '0;
      tuneReg <= '0;
      tuneTog <= 1'b0;
      ctrl <= '0;
      errCnt <= '0;
      inFrame <= 1'b0;
    end else if (csActive && bitCount != 6'd40) begin
      rxShift <= {rxShift[37:0], bus.spiMosi};
      if (bitCount == 6'd0) begin
        inFrame <= 1'b1;
        readShift <= '0;
        if (inFrame && errCnt != 8'hFF) errCnt <= errCnt + 8'd1;
      end
      if (bitCount == 6'd7) readShift <= cmd[7] ? readData : 32'h0;
      else if (bitCount >= 6'd8) readShift <= {readShift[30:0], 1'b0};
      if (bitCount == 6'd39) begin
        inFrame <= 1'b0;
        if (!frameCmd[7])
          case (frameCmd[6:0])
            7'd0: begin
              tuneReg <= frameData;
              tuneTog <= ~tuneTog;
            end
            7'd1: tunePend <= frameData;
            7'd2: begin
              tuneReg <= tunePend;
              tuneTog <= ~tuneTog;
            end
            7'd3: ctrl <= frameData[3:0];
            default: if (errCnt != 8'hFF) errCnt <= errCnt + 8'd1;
          endcase
      end
    end
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: directed frames with a readback scoreboard for spi_reg_slave
module tb_spi_reg_slave;
  logic spiClk, nReset;
  spi_reg_slave_if bus ();
  spi_reg_slave dut (.spiClk(spiClk), .nReset(nReset), .bus(bus));
  int nCmp = 0, nErr = 0;
  logic [31:0] expQ[$];
  logic [31:0] rd, preTw;
  logic preTg;
  initial spiClk = 1'b0;
  always #5 spiClk = ~spiClk;
  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Drives n bits from falling edges; samples MISO on falling edges; optional reset on edge rstAt+1
  task automatic frame(input logic [7:0] c, input logic [31:0] d, input int n, input int rstAt,
                       output logic [31:0] r);
    logic [39:0] f;
    f = {c, d};
    r = '0;
    @(negedge spiClk);
    bus.nSpiCs = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) @(negedge spiClk);
      if (i >= 8 && i <= 39) r[39 - i] = bus.spiMiso;
      if (i == 39) begin
        preTw = bus.tuningWord;
        preTg = bus.tuneToggle;
      end
      if (i < n) begin
        bus.spiMosi = i < 40 ? f[39 - i] : 1'($urandom);
        if (i == rstAt) nReset = 1'b0;
        @(posedge spiClk);
      end
    end
    bus.nSpiCs = 1'b1;
    nReset = 1'b1;
  endtask
  task automatic readReg(input logic [6:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] r;
    expQ.push_back(exp);
    frame({1'b1, a}, 32'h0, 40, -1, r);
    check(tag, r, expQ.pop_front());
  endtask
  initial begin
    nReset = 1'b0;
    bus.nSpiCs = 1'b1;
    bus.spiMosi = 1'b0;
    repeat (3) @(negedge spiClk);
    check("rst_tw", bus.tuningWord, 32'h0);
    check("rst_tg", {31'h0, bus.tuneToggle}, 32'h0);
    check("rst_ctrl", {28'h0, bus.bandSel, bus.txEnable}, 32'h0);
    check("rst_err", {24'h0, bus.errCount}, 32'h0);
    check("rst_miso", {31'h0, bus.spiMiso}, 32'h0);
    nReset = 1'b1;
    frame(8'h00, 32'h0A3D70A4, 40, -1, rd);
    check("tune_pre_tw", preTw, 32'h0);
    check("tune_pre_tg", {31'h0, preTg}, 32'h0);
    check("tune_tw", bus.tuningWord, 32'h0A3D70A4);
    check("tune_tg", {31'h0, bus.tuneToggle}, 32'h1);
    check("wr_miso_zero", rd, 32'h0);
    frame(8'h01, 32'h12345678, 40, -1, rd);
    check("pend_tw", bus.tuningWord, 32'h0A3D70A4);
    check("pend_tg", {31'h0, bus.tuneToggle}, 32'h1);
    frame(8'h02, 32'hDEADBEEF, 40, -1, rd);
    check("commit_pre_tw", preTw, 32'h0A3D70A4);
    check("commit_tw", bus.tuningWord, 32'h12345678);
    check("commit_tg", {31'h0, bus.tuneToggle}, 32'h0);
    readReg(7'h01, 32'h12345678, "rd_pend");
    readReg(7'h02, 32'h0, "rd_commit");
    frame(8'h03, 32'h0000000B, 40, -1, rd);
    check("ctrl_tx", {31'h0, bus.txEnable}, 32'h1);
    check("ctrl_band", {29'h0, bus.bandSel}, 32'h5);
    readReg(7'h03, 32'h0000000B, "rd_ctrl");
    check("rd_noeffect_tw", bus.tuningWord, 32'h12345678);
    check("rd_noeffect_ctrl", {28'h0, bus.bandSel, bus.txEnable}, 32'hB);
    readReg(7'h00, 32'h12345678, "rd_tune");
    frame(8'h00, 32'hFFFFFFFF, 20, -1, rd);
    readReg(7'h04, 32'h000001A5, "rd_status_trunc");
    check("trunc_tw", bus.tuningWord, 32'h12345678);
    check("trunc_tg", {31'h0, bus.tuneToggle}, 32'h0);
    check("trunc_ctrl", {28'h0, bus.bandSel, bus.txEnable}, 32'hB);
    frame(8'h00, 32'hCAFEF00D, 48, -1, rd);
    check("long_tw", bus.tuningWord, 32'hCAFEF00D);
    check("long_tg", {31'h0, bus.tuneToggle}, 32'h1);
    check("long_err", {24'h0, bus.errCount}, 32'h1);
    frame(8'h05, 32'h55AA55AA, 40, -1, rd);
    check("bad_err", {24'h0, bus.errCount}, 32'h2);
    check("bad_tw", bus.tuningWord, 32'hCAFEF00D);
    check("bad_tg", {31'h0, bus.tuneToggle}, 32'h1);
    check("bad_ctrl", {28'h0, bus.bandSel, bus.txEnable}, 32'hB);
    frame(8'h04, 32'h0, 40, -1, rd);
    check("status_wr_err", {24'h0, bus.errCount}, 32'h3);
    frame(8'h00, 32'h11111111, 30, 29, rd);
    check("midrst_tw", bus.tuningWord, 32'h0);
    check("midrst_tg", {31'h0, bus.tuneToggle}, 32'h0);
    check("midrst_ctrl", {28'h0, bus.bandSel, bus.txEnable}, 32'h0);
    check("midrst_err", {24'h0, bus.errCount}, 32'h0);
    readReg(7'h04, 32'h000000A5, "rd_status_after_rst");
    readReg(7'h01, 32'h0, "rd_pend_after_rst");
    for (int k = 0; k < 300; k++) frame(8'h7F, 32'($urandom), 40, -1, rd);
    check("sat_err", {24'h0, bus.errCount}, 32'hFF);
    readReg(7'h04, 32'h0000FFA5, "rd_status_sat");
    check("sat_tw", bus.tuningWord, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

SPI-domain command/register front end for the WSPR exciter. It decodes 40-bit framed commands from the ESP32 and holds the NCO tuning word plus transmitter control bits. It issues a toggle-based commit handshake that the sysClk-domain NCO stage synchronizes, and it provides register readback on spiMiso. It sits between the ESP32 SPI pins and the NCO/sequencer.

## Interface
- No parameters; register map and frame length are fixed.
- spiClk  in  1  SPI clock from ESP32; all state advances on its rising edge.
- nReset  in  1  Reset, synchronous, active-low; clock spiClk. Acts regardless of nSpiCs.
- nSpiCs  in  1  Chip select, active-low; high asynchronously clears the bit counter only.
- spiMosi  in  1  Serial data in, MSB first, sampled on spiClk rising edge.
- spiMiso  out  1  Serial data out, MSB first, updated after spiClk rising edge; master samples on falling edge.
- tuningWord  out  32  Committed NCO tuning word; stable between commits.
- tuneToggle  out  1  Inverts once per commit of tuningWord; consumer syncs it (2FF) and edge-detects with XOR.
- txEnable  out  1  CTRL[0]; gates PA drive downstream.
- bandSel  out  3  CTRL[3:1]; LPF/band relay select.
- errCount  out  8  Saturating count of protocol errors.

## Operation
- Frame = 40 bits within one nSpiCs-low window: cmd[7:0] then data[31:0]. cmd[7] = 1 means read; cmd[6:0] = address.
- bitCount runs 0..40. It increments on each rising edge with nSpiCs low and saturates at 40. Bits after the 40th are ignored; there is no second commit and no error.
- Register map:
  - 0x00 TUNE (RW): write sets tuningWord and inverts tuneToggle.
  - 0x01 TUNE_PEND (RW): write only stores the value.
  - 0x02 COMMIT (W): data ignored; sets tuningWord = TUNE_PEND and inverts tuneToggle. Reads as 0.
  - 0x03 CTRL (RW): bits[3:0] used; reads with [31:4] = 0.
  - 0x04 STATUS (R): {16'h0, errCount, 8'hA5}.
  - Other addresses read 0.
- Write effect happens on the rising edge that samples bit 40 (bitCount==39). Write frames drive spiMiso = 0 throughout.
- Read: on the edge that samples bit 8 (bitCount==7), the selected register is loaded into a 32-bit readShift register. spiMiso = readShift[31]. Each following edge shifts readShift left, for 32 bits total. After bit 40, spiMiso = 0. A read frame has no write side effect.
- inFrame flag:
  - Set on the first bit of a frame; cleared on the bit-40 edge.
  - It is not cleared by nSpiCs.
  - If the first bit of a frame arrives while inFrame = 1, the previous frame was truncated: errCount increments and the truncated frame has no effect.
- Any write to an unknown address or to STATUS increments errCount.
- errCount saturates at 255. Increments from truncation happen at bit 0 and increments from bad writes at bit 40, so they can never occur on the same edge.

## Timing
- Reset values when nReset is sampled low on a rising edge: tuningWord 0, TUNE_PEND 0, tuneToggle 0, txEnable 0, bandSel 0, errCount 0, spiMiso 0, readShift 0, inFrame 0, bitCount 0.
- Reset has priority over all frame activity. Reset mid-frame aborts the frame with no commit and no error count.
- Firmware must supply ≥1 spiClk edge while nReset is low; there is no effect without clock edges.
- Commit latency: tuningWord and tuneToggle change on the same rising edge (bit 40). tuningWord is stable for at least the next 40 spiClk periods. This is far longer than the consumer's 2FF + edge-detect latency at 180 MHz.
- Read data: readShift[31] appears on spiMiso after the bit-8 edge, so the master's falling-edge sample of bit 9 sees data bit 31. Data bit 0 is sampled on the falling edge of bit 40.
- nSpiCs high asynchronously zeroes bitCount. No other state changes on CS deassertion.

## Test plan
- Reset, then write 0x00 with 0x0A3D70A4 -> tuningWord = 0x0A3D70A4 and tuneToggle 0→1, both exactly at the bit-40 edge.
- Write 0x01 with 0x12345678 -> tuningWord and tuneToggle unchanged. Then write 0x02 -> tuningWord = 0x12345678 and tuneToggle inverts.
- Write 0x03 with 0x0000000B, then read 0x83 -> txEnable = 1, bandSel = 5, MISO returns 0x0000000B; no side effects from the read.
- Send a 20-bit frame, raise nSpiCs, then send a full read of 0x84 -> returned STATUS = 0x000001A5; tuningWord and CTRL unchanged.
- Send a 48-bit write to 0x00 -> exactly one tuneToggle inversion. Write to 0x05 -> errCount increments and nothing else changes. Pulse nReset low at bit 30 of a write -> all outputs 0 and no commit.
- Issue 300 bad-address writes -> errCount saturates at 0xFF.
